// File: rtl/shift_right_arbiter.sv
// shift_right_arbiter: round-robin share of one logical right shifter between
// two requesters, with a 1-deep registered result stage tagged by requester ID
// and a sticky bit (OR of shifted-out bits) for rounding.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   req0_valid/ready/a/b     requester 0 handshake, operand, shift amount
//   req1_valid/ready/a/b     requester 1 handshake, operand, shift amount
//   out_valid/out_ready      result handshake (out_valid registered)
//   out_c                    registered a >> b (zero fill)
//   out_sticky               registered OR of bits shifted out of a
//   out_id                   requester that owns out_c
//   req*_ready are combinational grants (accepted this cycle).

// Logical right shift with sticky; b >= N yields c=0, sticky=|a.
module shift_right #(
  parameter int unsigned N = 16,
  parameter int unsigned S = 4
) (
  input  logic [N-1:0] a,
  input  logic [S-1:0] b,
  output logic [N-1:0] c,
  output logic         sticky
);

  logic [N-1:0] lost_mask;

  always_comb begin
    c         = '0;
    lost_mask = '1;
    if (32'(b) < N) begin
      c         = a >> b;
      lost_mask = ~({N{1'b1}} << b);
    end
    sticky = |(a & lost_mask);
  end

endmodule

module shift_right_arbiter #(
  parameter int unsigned N = 16,
  parameter int unsigned S = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [S-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [S-1:0] req1_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_c,
  output logic         out_sticky,
  output logic         out_id
);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]   state;
  logic [0:0]   state_nxt;
  logic         ptr;          // 0 favours req0, 1 favours req1
  logic         can_accept;
  logic         grant0;
  logic         grant1;
  logic         grant_any;
  logic [N-1:0] sel_a;
  logic [S-1:0] sel_b;
  logic [N-1:0] sr_c;
  logic         sr_sticky;

  // Grant and next-state; rst_n gating keeps ready low while in reset.
  always_comb begin
    can_accept = 1'b0;
    grant0     = 1'b0;
    grant1     = 1'b0;
    state_nxt  = state;
    can_accept = (state == EMPTY) || out_ready;
    grant0     = rst_n && can_accept && req0_valid && (!req1_valid || !ptr);
    grant1     = rst_n && can_accept && req1_valid && (!req0_valid ||  ptr);
    if (grant0 || grant1) begin
      state_nxt = FULL;
    end else if ((state == FULL) && out_ready) begin
      state_nxt = EMPTY;
    end
  end

  assign grant_any  = grant0 | grant1;
  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign sel_a      = grant1 ? req1_a : req0_a;
  assign sel_b      = grant1 ? req1_b : req0_b;
  assign out_valid  = (state == FULL);

  shift_right #(.N(N), .S(S)) u_shift (
    .a      (sel_a),
    .b      (sel_b),
    .c      (sr_c),
    .sticky (sr_sticky)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Result stage and pointer load only on an accepted grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_c      <= '0;
      out_sticky <= 1'b0;
      out_id     <= 1'b0;
      ptr        <= 1'b0;
    end else if (grant_any) begin
      out_c      <= sr_c;
      out_sticky <= sr_sticky;
      out_id     <= grant1;
      ptr        <= grant0;   // last winner drops to lowest priority
    end
  end

endmodule

// File: tb/tb_shift_right_arbiter.sv
module tb_shift_right_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready;
  logic [15:0] req0_a;
  logic [3:0]  req0_b;
  logic        req1_valid, req1_ready;
  logic [15:0] req1_a;
  logic [3:0]  req1_b;
  logic        out_valid, out_ready;
  logic [15:0] out_c;
  logic        out_sticky, out_id;

  int vectors;
  int errors;

  shift_right_arbiter #(.N(16), .S(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_c      (out_c),
    .out_sticky (out_sticky),
    .out_id     (out_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; out_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 16'h1234; req0_b = 4'd1;
    req1_valid = 1'b1; req1_a = 16'h5678; req1_b = 4'd2;
    #1;
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    @(posedge clk); #1;
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid_edge: got %b want 0", out_valid); end
    vectors++; if (out_c !== 16'h0) begin errors++; $display("FAIL reset_c: got %h want 0000", out_c); end
    vectors++; if (out_sticky !== 1'b0) begin errors++; $display("FAIL reset_sticky: got %b want 0", out_sticky); end
    vectors++; if (out_id !== 1'b0) begin errors++; $display("FAIL reset_id: got %b want 0", out_id); end
    vectors++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready}); end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 16'hF0F1; req0_b = 4'd4; out_ready = 1'b0;
    #1;
    vectors++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL single_ready: got %b want 10", {req0_ready, req1_ready}); end
    @(posedge clk); #1;
    vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", out_valid); end
    vectors++; if (out_c !== 16'h0F0F) begin errors++; $display("FAIL single_c: got %h want 0f0f", out_c); end
    vectors++; if (out_sticky !== 1'b1) begin errors++; $display("FAIL single_sticky: got %b want 1", out_sticky); end
    vectors++; if (out_id !== 1'b0) begin errors++; $display("FAIL single_id: got %b want 0", out_id); end
    @(negedge clk);
    req0_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain_valid: got %b want 0", out_valid); end
    vectors++; if (out_c !== 16'h0F0F) begin errors++; $display("FAIL single_empty_hold_c: got %h want 0f0f", out_c); end
  endtask

  // Pointer favours req1 after the single req0 accept, so ids run 1,0,1,0...
  task automatic test_contention();
    logic        exp_id;
    logic [15:0] exp_c;
    logic        exp_s;
    req0_a = 16'hA5A5; req0_b = 4'd1;   // -> 52D2, sticky 1
    req1_a = 16'h0F00; req1_b = 4'd8;   // -> 000F, sticky 0
    for (int i = 0; i < 6; i++) begin
      exp_id = (i % 2 == 0);
      exp_c  = exp_id ? 16'h000F : 16'h52D2;
      exp_s  = !exp_id;
      @(negedge clk);
      req0_valid = 1'b1; req1_valid = 1'b1; out_ready = 1'b1;
      #1;
      vectors++; if ({req0_ready, req1_ready} !== {!exp_id, exp_id}) begin errors++; $display("FAIL contention_ready[%0d]: got %b want %b", i, {req0_ready, req1_ready}, {!exp_id, exp_id}); end
      @(posedge clk); #1;
      vectors++; if ({out_valid, out_id} !== {1'b1, exp_id}) begin errors++; $display("FAIL contention_id[%0d]: got v%b id%b want v1 id%b", i, out_valid, out_id, exp_id); end
      vectors++; if ({out_c, out_sticky} !== {exp_c, exp_s}) begin errors++; $display("FAIL contention_data[%0d]: got %h/%b want %h/%b", i, out_c, out_sticky, exp_c, exp_s); end
    end
  endtask

  // Holding id0 result (52D2); pointer now favours req1.
  task automatic test_backpressure();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      out_ready = 1'b0;
      #1;
      vectors++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL stall_ready[%0d]: got %b want 00", i, {req0_ready, req1_ready}); end
      @(posedge clk); #1;
      vectors++; if ({out_valid, out_id, out_c} !== {1'b1, 1'b0, 16'h52D2}) begin errors++; $display("FAIL stall_hold[%0d]: got v%b id%b c%h want v1 id0 c52d2", i, out_valid, out_id, out_c); end
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    vectors++; if ({req0_ready, req1_ready} !== 2'b01) begin errors++; $display("FAIL release_ready: got %b want 01", {req0_ready, req1_ready}); end
    @(posedge clk); #1;
    vectors++; if ({out_valid, out_id, out_c} !== {1'b1, 1'b1, 16'h000F}) begin errors++; $display("FAIL release_out: got v%b id%b c%h want v1 id1 c000f", out_valid, out_id, out_c); end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL release_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_bounds();
    logic [15:0] va [3];
    logic [3:0]  vb [3];
    logic [15:0] ec [3];
    logic        es [3];
    va[0] = 16'h8001; vb[0] = 4'd0;  ec[0] = 16'h8001; es[0] = 1'b0;
    va[1] = 16'hFFFF; vb[1] = 4'd15; ec[1] = 16'h0001; es[1] = 1'b1;
    va[2] = 16'h4000; vb[2] = 4'd15; ec[2] = 16'h0000; es[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req0_valid = 1'b1; req0_a = va[i]; req0_b = vb[i]; out_ready = 1'b1;
      @(posedge clk); #1;
      vectors++; if ({out_valid, out_c, out_sticky} !== {1'b1, ec[i], es[i]}) begin errors++; $display("FAIL bounds[%0d]: got v%b c%h s%b want v1 c%h s%b", i, out_valid, out_c, out_sticky, ec[i], es[i]); end
    end
    @(negedge clk);
    req0_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  // req1 alone x3 and an idle cycle leave pointer favouring req0.
  task automatic test_pointer_hold();
    req1_a = 16'h0010; req1_b = 4'd4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req1_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      vectors++; if ({out_valid, out_id, out_c} !== {1'b1, 1'b1, 16'h0001}) begin errors++; $display("FAIL ptr_req1[%0d]: got v%b id%b c%h want v1 id1 c0001", i, out_valid, out_id, out_c); end
    end
    @(negedge clk);
    req1_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1; req0_a = 16'h0100; req0_b = 4'd8;
    #1;
    vectors++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL ptr_both_ready: got %b want 10", {req0_ready, req1_ready}); end
    @(posedge clk); #1;
    vectors++; if ({out_id, out_c} !== {1'b0, 16'h0001}) begin errors++; $display("FAIL ptr_both_out: got id%b c%h want id0 c0001", out_id, out_c); end
  endtask

  // Two more contended accepts (req1 then req0) leave pointer favouring req1
  // before reset; reset must return it to req0.
  task automatic test_async_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      req0_valid = 1'b1; req1_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
    end
    vectors++; if (out_id !== 1'b0) begin errors++; $display("FAIL prereset_id: got %b want 0", out_id); end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++; if ({out_valid, out_c, out_sticky, out_id} !== {1'b1 ^ 1'b1, 16'h0, 1'b0, 1'b0}) begin errors++; $display("FAIL async_reset_out: got v%b c%h s%b id%b want v0 c0000 s0 id0", out_valid, out_c, out_sticky, out_id); end
    vectors++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL async_reset_ready: got %b want 00", {req0_ready, req1_ready}); end
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL postreset_ready: got %b want 10", {req0_ready, req1_ready}); end
    @(posedge clk); #1;
    vectors++; if ({out_valid, out_id} !== 2'b10) begin errors++; $display("FAIL postreset_out: got v%b id%b want v1 id0", out_valid, out_id); end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_bounds();
    test_pointer_hold();
    test_async_reset();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
